// File: rtl/fix_pkg.sv
// fix_pkg: shared fixed-point constants and multiplier FSM states.
// Used by fix_mult_seq and by the fix_adder-side blocks.
package fix_pkg;

   localparam int FIX_Q = 8;
   localparam int FIX_N = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } fix_state_t;

endpackage

// File: rtl/fix_mult_seq.sv
// fix_mult_seq: sequential sign-magnitude Q-format multiplier.
// Shift-add over N-1 cycles, truncating, saturating output.
module fix_mult_seq
   import fix_pkg::*;
#(
   parameter int Q = FIX_Q,
   parameter int N = FIX_N
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] p,
   output logic         ovf
);

   localparam int AW = 2 * (N - 1);
   localparam int CW = $clog2(N);

   fix_state_t    r_state;
   fix_state_t    w_state_nxt;
   logic          r_sign;
   logic [N-2:0]  r_mag_a;
   logic [N-2:0]  r_mag_b;
   logic [AW-1:0] r_acc;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_p;
   logic          r_ovf;

   logic          w_take;
   logic          w_last;
   logic [AW-1:0] w_addend;
   logic [AW-1:0] w_acc_nxt;
   logic [AW-1:0] w_shr;
   logic          w_ovf;
   logic [N-2:0]  w_mag;
   logic [N-1:0]  w_p_nxt;

   assign in_ready  = (r_state == IDLE);
   assign out_valid = (r_state == DONE);
   assign p         = r_p;
   assign ovf       = r_ovf;

   assign w_take = in_valid && (r_state == IDLE);
   assign w_last = (r_state == BUSY) && (r_cnt == CW'(N - 2));

   // Partial product for the current multiplier bit, and the final scaling
   assign w_addend  = r_mag_b[r_cnt]
                    ? ({{(N-1){1'b0}}, r_mag_a} << r_cnt)
                    : '0;
   assign w_acc_nxt = r_acc + w_addend;
   assign w_shr     = w_acc_nxt >> Q;
   assign w_ovf     = |w_shr[AW-1:N-1];
   assign w_mag     = w_ovf ? '1 : w_shr[N-2:0];
   assign w_p_nxt   = {r_sign && (w_mag != '0), w_mag};

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: if (in_valid) w_state_nxt = BUSY;
         BUSY: if (w_last) w_state_nxt = DONE;
         DONE: if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Operand capture, shift-add accumulation and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sign  <= 1'b0;
         r_mag_a <= '0;
         r_mag_b <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_p     <= '0;
         r_ovf   <= 1'b0;
      end else if (w_take) begin
         r_sign  <= a[N-1] ^ b[N-1];
         r_mag_a <= a[N-2:0];
         r_mag_b <= b[N-2:0];
         r_acc   <= '0;
         r_cnt   <= '0;
      end else if (r_state == BUSY) begin
         r_acc <= w_acc_nxt;
         r_cnt <= r_cnt + 1'b1;
         if (w_last) begin
            r_p   <= w_p_nxt;
            r_ovf <= w_ovf;
         end
      end
   end

endmodule

// File: tb/tb_fix_mult_seq.sv
// tb_fix_mult_seq: directed vector bench for fix_mult_seq.
// Table of products plus backpressure, reset and streaming sequences.
module tb_fix_mult_seq;
   import fix_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] p;
   logic        ovf;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] p;
      logic        ovf;
   } vec_t;

   vec_t vt[10];

   fix_mult_seq #(.Q(8), .N(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [16:0] model(input logic [15:0] va,
                                         input logic [15:0] vb);
      logic [29:0] prod;
      logic [21:0] sh;
      logic [14:0] mag;
      logic        o;
      prod = 30'(va[14:0]) * 30'(vb[14:0]);
      sh   = 22'(prod >> 8);
      o    = (sh > 22'd32767);
      mag  = o ? 15'h7FFF : sh[14:0];
      return {o, (va[15] ^ vb[15]) && (mag != 15'd0), mag};
   endfunction

   task automatic wait_valid(input string nm, output int lat);
      bit got;
      got = 1'b0;
      lat = 1;
      for (int k = 0; k < 40 && !got; k++) begin
         if (out_valid) got = 1'b1;
         else begin
            tick();
            lat++;
         end
      end
      if (!got) check({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic run_op(input string nm, input logic [15:0] va,
                         input logic [15:0] vb, input logic [15:0] ep,
                         input logic eovf);
      int lat;
      for (int k = 0; k < 40 && !in_ready; k++) tick();
      check({nm, "_rdy"}, 32'(in_ready), 32'd1);
      a = va;
      b = vb;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      a = ~va;
      b = ~vb;
      wait_valid(nm, lat);
      check({nm, "_lat"}, 32'(lat), 32'd16);
      check({nm, "_p"}, 32'(p), 32'(ep));
      check({nm, "_ovf"}, 32'(ovf), 32'(eovf));
      tick();
      check({nm, "_idle"}, {31'd0, out_valid, in_ready}, 32'd1);
   endtask

   initial begin : main
      logic [15:0] hold_p;
      logic [16:0] m;
      logic [15:0] oa[4];
      logic [15:0] ob[4];
      int lat;
      int prev;
      bit seen;

      vt[0] = '{16'h0180, 16'h0200, 16'h0300, 1'b0};
      vt[1] = '{16'h8180, 16'h0200, 16'h8300, 1'b0};
      vt[2] = '{16'h8180, 16'h8200, 16'h0300, 1'b0};
      vt[3] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1};
      vt[4] = '{16'h8000, 16'h0100, 16'h0000, 1'b0};
      vt[5] = '{16'h0001, 16'h8001, 16'h0000, 1'b0};
      vt[6] = '{16'h0080, 16'h0080, 16'h0040, 1'b0};
      vt[7] = '{16'h8040, 16'h0400, 16'h8100, 1'b0};
      vt[8] = '{16'h4000, 16'h0200, 16'h7FFF, 1'b1};
      vt[9] = '{16'h7FFF, 16'h0100, 16'h7FFF, 1'b0};

      #3;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_p", 32'(p), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      #2;

      for (int i = 0; i < 10; i++) begin
         run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b,
                vt[i].p, vt[i].ovf);
      end

      // backpressure in DONE with a stray in_valid pulse
      out_ready = 1'b0;
      a = 16'h0180;
      b = 16'h0200;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      wait_valid("bp", lat);
      check("bp_lat", 32'(lat), 32'd16);
      hold_p = p;
      check("bp_p", 32'(hold_p), 32'h0300);
      for (int i = 0; i < 10; i++) begin
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_hold", 32'(p), 32'(hold_p));
         check("bp_in_ready", 32'(in_ready), 32'd0);
         in_valid = (i == 3);
         a = 16'h7FFF;
         b = 16'h7FFF;
         tick();
      end
      in_valid = 1'b0;
      check("bp_end_p", 32'(p), 32'h0300);
      check("bp_end_ovf", 32'(ovf), 32'd0);
      out_ready = 1'b1;
      tick();
      check("bp_release", {31'd0, out_valid, in_ready}, 32'd1);

      // reset in BUSY cycle 7
      a = 16'h0180;
      b = 16'h0200;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      check("mid_busy", 32'(in_ready), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_in_ready", 32'(in_ready), 32'd1);
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_p", 32'(p), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      #2;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      check("arst_no_valid", 32'(seen), 32'd0);
      run_op("after_rst", 16'h0280, 16'h8180, 16'h83C0, 1'b0);

      // streaming with in_valid and out_ready held high
      oa[0] = 16'h0180; ob[0] = 16'h0200;
      oa[1] = 16'h8123; ob[1] = 16'h0345;
      oa[2] = 16'h7F00; ob[2] = 16'h0200;
      oa[3] = 16'h00FF; ob[3] = 16'h80FF;
      a = oa[0];
      b = ob[0];
      in_valid = 1'b1;
      prev = 0;
      for (int i = 0; i < 4; i++) begin
         wait_valid($sformatf("b2b%0d", i), lat);
         m = model(oa[i], ob[i]);
         check($sformatf("b2b%0d_p", i), 32'(p), 32'(m[15:0]));
         check($sformatf("b2b%0d_ovf", i), 32'(ovf), 32'(m[16]));
         if (i > 0) begin
            check($sformatf("b2b%0d_gap", i), 32'(cyc - prev), 32'd17);
         end
         prev = cyc;
         if (i < 3) begin
            a = oa[i+1];
            b = ob[i+1];
         end else begin
            in_valid = 1'b0;
         end
         tick();
      end
      check("b2b_end", {31'd0, out_valid, in_ready}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fix_mult_seq.md
FIX_MULT_SEQ -- requirements
Module: fix_mult_seq

Interface
REQ-001 The block SHALL have parameter Q, default 8, meaning the number of fractional magnitude bits.
REQ-002 The block SHALL have parameter N, default 16, meaning the total word width, with bit N-1 as sign and bits N-2..0 as magnitude.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands a, b are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 The block SHALL have port a, input, N bits: sign-magnitude multiplicand.
REQ-008 The block SHALL have port b, input, N bits: sign-magnitude multiplier.
REQ-009 The block SHALL have port out_valid, output, 1 bit: p and ovf are valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer (the fix_adder operand stage) accepts p.
REQ-011 The block SHALL have port p, output, N bits: sign-magnitude product in the same Q format.
REQ-012 The block SHALL have port ovf, output, 1 bit: the magnitude saturated.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE; in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-014 IDLE->BUSY SHALL occur when in_valid&&in_ready (handshake in cycle T): capture sign sa^sb, mag_a=a[N-2:0], mag_b=b[N-2:0], clear the 2(N-1)-bit accumulator, and set the counter to 0.
REQ-015 BUSY SHALL perform shift-add: each cycle, if mag_b bit[cnt]=1, add mag_a<<cnt to the accumulator; cnt increments; exactly N-1 BUSY cycles (T+1..T+N-1).
REQ-016 BUSY->DONE SHALL occur after the cycle with cnt=N-2; out_valid SHALL rise in cycle T+N (T+16 for default N).
REQ-017 Result magnitude SHALL be acc>>Q, truncated (no rounding).
REQ-018 If acc>>Q exceeds 2^(N-1)-1, the magnitude SHALL saturate to all ones and ovf=1; otherwise ovf=0.
REQ-019 If the final magnitude is 0, the sign bit SHALL be 0 (no negative zero); otherwise the sign is sa^sb.
REQ-020 DONE SHALL hold p/ovf/out_valid stable until out_valid&&out_ready, then go to IDLE next cycle.
REQ-021 in_valid asserted during BUSY or DONE SHALL be ignored; operands are not captured and in_ready stays 0.
REQ-022 Input changes on a and b after capture SHALL NOT affect the result in flight.
REQ-023 The throughput SHALL be one product per N+1 cycles minimum (capture, N-1 BUSY, 1 DONE handshake).

Reset
REQ-024 When rst_n=0, asynchronously: state SHALL be IDLE, in_ready=1, out_valid=0, p=0, ovf=0, and the accumulator and counter SHALL be 0.
REQ-025 Reset asserted mid-BUSY or in DONE SHALL abandon the operation; no out_valid SHALL follow deassertion.
REQ-026 After rst_n deasserts, the first capture SHALL be possible in the first clock cycle.

Structure
REQ-027 Shared package fix_pkg SHALL hold the default Q/N constants and the FSM state encoding (IDLE, BUSY, DONE), for reuse by fix_adder-side blocks.
REQ-028 The design SHALL use no sub-module; the FSM, shift-add datapath and saturation logic SHALL be inline in a single module.
REQ-029 The output p SHALL be registered and directly pin-compatible with the fix_adder a/b inputs (same N, Q, sign-magnitude).

Verification
REQ-030 The bench SHALL check a=0x0180 (1.5), b=0x0200 (2.0) -> p=0x0300, ovf=0, out_valid exactly 16 cycles after the handshake.
REQ-031 The bench SHALL check a=0x8180 (-1.5), b=0x0200 -> p=0x8300; a=0x8180, b=0x8200 -> p=0x0300.
REQ-032 The bench SHALL check a=0x7FFF, b=0x7FFF -> p=0x7FFF, ovf=1; a=0x8000, b=0x0100 -> p=0x0000; a=0x0001, b=0x8001 -> p=0x0000 (truncated, sign cleared).
REQ-033 The bench SHALL check backpressure: out_ready=0 for 10 cycles in DONE -> p/out_valid stable, in_ready=0, a second in_valid pulse ignored; out_ready=1 -> IDLE next cycle.
REQ-034 The bench SHALL check that rst_n pulsed low at BUSY cycle 7 -> out_valid never asserts for that operation, in_ready=1 immediately, and the next product is correct.
REQ-035 The bench SHALL check back-to-back operations with out_ready=1 and in_valid=1 constantly -> one result per 17 cycles, each matching a reference model.
